reg_share_arb: RTL and testbench
================================

REG_SHARE_ARB -- requirements
Module: reg_share_arb

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum consecutive writes one owner may chain under lock.
REQ-002 Port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 Port reset, input, 1, synchronous, active-high reset.
REQ-004 Port req, input, 4, per-requester write request; bit i belongs to requester i.
REQ-005 Port lock, input, 4, per-requester hold-ownership request; sampled only for the current owner.
REQ-006 Ports wdata0..wdata3, input, 8 each, write data of requesters 0..3.
REQ-007 Port grant, output, 4, one-hot current owner; all zero when idle.
REQ-008 Port ack, output, 4, one-cycle pulse to the owner in the cycle its data is written.
REQ-009 Port reg_en, output, 1, load enable to the shared 8-bit register.
REQ-010 Port reg_d, output, 8, data to the shared 8-bit register.
REQ-011 Port forced_rel, output, 1, one-cycle pulse when the hold limit revokes ownership.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and OWN.
REQ-013 In IDLE with req nonzero, the block SHALL select the winner round-robin, starting the search at pointer ptr and wrapping 3->0, and SHALL enter OWN with grant one-hot on the winner at the next edge.
REQ-014 In IDLE, grant, ack, reg_en and forced_rel SHALL be 0 and reg_d SHALL be 8'h00.
REQ-015 In OWN, reg_en SHALL be 1, reg_d SHALL equal wdata of the owner, and ack SHALL be 1 on the owner bit only, all combinationally from registered state.
REQ-016 Latency: req asserted before edge N yields grant in cycle N+1 and the register load at edge N+2.
REQ-017 At the end of an OWN cycle, if lock[owner]=1 and req[owner]=1 and hold count < MAX_HOLD-1, the block SHALL stay in OWN with the same owner and increment the hold count.
REQ-018 Otherwise the block SHALL return to IDLE, clear the hold count, and set ptr = owner+1 mod 4.
REQ-019 When the stay condition fails only because hold count reached MAX_HOLD-1, forced_rel SHALL pulse during that final OWN cycle.
REQ-020 req bits of non-owners SHALL be ignored while in OWN; they are arbitrated only in IDLE.
REQ-021 Every granted request SHALL produce exactly one write per OWN cycle, and one IDLE cycle SHALL separate consecutive owners.
REQ-022 Deasserting req[owner] while in OWN SHALL NOT cancel the current write; it only prevents extension.
REQ-023 Hold count SHALL be a 4-bit saturating-free counter; MAX_HOLD is legal in the range 1..15.

Reset
REQ-024 On reset=1 at a clock edge, the state SHALL become IDLE, ptr 0, hold count 0, and all outputs SHALL become 0.
REQ-025 Reset asserted during OWN SHALL abort ownership with no ack or reg_en in the following cycle.
REQ-026 The first arbitration after reset SHALL favour requester 0.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE=1'b0, OWN=1'b1), NREQ=4 and the data width 8.
REQ-028 The round-robin selection SHALL be a combinational sub-module rr_pick4 (inputs req, ptr; outputs one-hot winner, valid).
REQ-029 The shared 8-bit enabled register SHALL remain outside this block.

Verification
REQ-030 reset, then req=4'b0001, wdata0=8'hA5 -> grant=0001 cycle 2, reg_en=1, reg_d=A5, ack=0001 for one cycle, then IDLE.
REQ-031 req=4'b1111 held, lock=0 -> owners in order 0,1,2,3,0, each for one OWN cycle separated by one IDLE cycle.
REQ-032 req=4'b0100, lock=4'b0100 held, MAX_HOLD=8 -> 8 consecutive writes of wdata2, forced_rel on the 8th, then ptr=3.
REQ-033 Owner 1 locked, lock dropped after 3 writes -> exactly 3 acks to requester 1, next owner is the lowest requester at or after 2.
REQ-034 reset asserted mid-OWN with req=4'b1000 -> next cycle grant=0, reg_en=0, and the next grant goes to requester 0 if it requests.

Source files
------------

// File: rtl/reg_share_arb_pkg.sv
// reg_share_arb_pkg: shared types and constants for the register-sharing arbiter
package reg_share_arb_pkg;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    // Index of the set bit in a one-hot requester vector.
    function automatic logic [1:0] oh2idx(input logic [NREQ-1:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

endpackage

// File: rtl/reg_share_arb_rr_pick4.sv
// rr_pick4: combinational round-robin pick among four requesters starting at ptr
module rr_pick4
    import reg_share_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [NREQ-1:0] win,
    output logic            valid
);

    logic [2*NREQ-1:0] dbl_r;
    logic [2*NREQ-1:0] dbl_w;
    logic [NREQ-1:0]   rot;
    logic [NREQ-1:0]   first;

    // Rotate so ptr sits at bit 0, keep the lowest set bit, rotate back.
    always_comb begin
        dbl_r = {req, req} >> ptr;
        rot   = dbl_r[NREQ-1:0];
        first = rot & (~rot + 4'd1);
        dbl_w = {first, first} << ptr;
        win   = dbl_w[2*NREQ-1:NREQ];
        valid = |req;
    end

endmodule

// File: rtl/reg_share_arb.sv
// reg_share_arb: round-robin owner selection with lockable write chaining onto a shared register
module reg_share_arb
    import reg_share_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] lock,
    input  logic [DW-1:0]   wdata0,
    input  logic [DW-1:0]   wdata1,
    input  logic [DW-1:0]   wdata2,
    input  logic [DW-1:0]   wdata3,
    output logic [NREQ-1:0] grant,
    output logic [NREQ-1:0] ack,
    output logic            reg_en,
    output logic [DW-1:0]   reg_d,
    output logic            forced_rel
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_e          state_q, state_d;
    logic [1:0]      own_q, own_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [3:0]      hold_q, hold_d;
    logic [NREQ-1:0] win;
    logic            valid;
    logic            own;
    logic            keep;
    logic            stay;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .win   (win),
        .valid (valid)
    );

    // Outputs decode purely from the owner state; keep/stay decide extension.
    always_comb begin
        own        = state_q == OWN;
        keep       = own && lock[own_q] && req[own_q];
        stay       = keep && hold_q < HOLD_LAST;
        grant      = own ? 4'b0001 << own_q : '0;
        ack        = grant;
        reg_en     = own;
        reg_d      = !own ? '0 : own_q == 2'd0 ? wdata0 : own_q == 2'd1 ? wdata1 : own_q == 2'd2 ? wdata2 : wdata3;
        forced_rel = keep && !stay;
    end

    // Next state: arbitrate in IDLE, extend or release in OWN.
    always_comb begin
        state_d = (own ? stay : valid) ? OWN : IDLE;
        own_d   = !own && valid ? oh2idx(win) : own_q;
        hold_d  = stay ? hold_q + 4'd1 : '0;
        ptr_d   = own && !stay ? own_q + 2'd1 : ptr_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            own_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_reg_share_arb.sv
// tb_reg_share_arb: scoreboard bench for the register-sharing arbiter
module tb_reg_share_arb;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] lock = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0, wdata2 = '0, wdata3 = '0;
    logic [3:0] grant, ack;
    logic       reg_en, forced_rel;
    logic [7:0] reg_d;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] d;
        logic       f;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    bit         mon_on = 1'b0;
    bit         prev_en = 1'b0;
    logic [3:0] prev_g = '0;

    reg_share_arb #(.MAX_HOLD(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .lock       (lock),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .wdata2     (wdata2),
        .wdata3     (wdata3),
        .grant      (grant),
        .ack        (ack),
        .reg_en     (reg_en),
        .reg_d      (reg_d),
        .forced_rel (forced_rel)
    );

    always #5 clk = ~clk;

    // Every write cycle must match the next expected write; every other cycle must be fully idle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            checks++;
            if (reg_en === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write grant=%b reg_d=%h", grant, reg_d);
                end else begin
                    e = sb.pop_front();
                    if ({grant, ack, reg_d, forced_rel} !== {e.g, e.g, e.d, e.f}) begin
                        errors++;
                        $display("FAIL write got grant=%b ack=%b reg_d=%h forced_rel=%b want grant=%b ack=%b reg_d=%h forced_rel=%b",
                                 grant, ack, reg_d, forced_rel, e.g, e.g, e.d, e.f);
                    end
                end
                if (prev_en) begin
                    checks++;
                    if (grant !== prev_g) begin
                        errors++;
                        $display("FAIL owner_switch_without_idle got grant=%b want grant=%b", grant, prev_g);
                    end
                end
            end else if ({reg_en, grant, ack, reg_d, forced_rel} !== '0) begin
                errors++;
                $display("FAIL idle_outputs got reg_en=%b grant=%b ack=%b reg_d=%h forced_rel=%b want all zero",
                         reg_en, grant, ack, reg_d, forced_rel);
            end
            prev_en = reg_en === 1'b1;
            prev_g  = grant;
        end
    end

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got pending=%0d want pending=0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({grant, ack, reg_en, reg_d, forced_rel} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got grant=%b ack=%b reg_en=%b reg_d=%h forced_rel=%b want all zero",
                     grant, ack, reg_en, reg_d, forced_rel);
        end
        @(posedge clk); #1 reset = 1'b0;
        mon_on = 1'b1;
    endtask

    task automatic test_single();
        wdata0 = 8'hA5;
        sb.push_back('{4'b0001, 8'hA5, 1'b0});
        @(posedge clk); #1 req = 4'b0001;
        @(posedge clk); #1 req = 4'b0000;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL single_latency got grant=%b want grant=0001", grant);
        end
        drain();
    endtask

    task automatic test_round_robin();
        do_reset();
        wdata0 = 8'h10; wdata1 = 8'h21; wdata2 = 8'h32; wdata3 = 8'h43;
        lock = '0;
        sb.push_back('{4'b0001, 8'h10, 1'b0});
        sb.push_back('{4'b0010, 8'h21, 1'b0});
        sb.push_back('{4'b0100, 8'h32, 1'b0});
        sb.push_back('{4'b1000, 8'h43, 1'b0});
        sb.push_back('{4'b0001, 8'h10, 1'b0});
        @(posedge clk); #1 req = 4'b1111;
        repeat (9) @(posedge clk);
        #1 req = 4'b0000;
        drain();
    endtask

    task automatic test_hold();
        do_reset();
        wdata2 = 8'hC3; wdata3 = 8'h3C;
        for (int i = 0; i < 8; i++) sb.push_back('{4'b0100, 8'hC3, i == 7});
        @(posedge clk); #1 req = 4'b0100; lock = 4'b0100;
        repeat (9) @(posedge clk);
        #1 req = 4'b0000; lock = 4'b0000;
        drain();
        sb.push_back('{4'b1000, 8'h3C, 1'b0});
        @(posedge clk); #1 req = 4'b1111;
        @(posedge clk); #1 req = 4'b0000;
        drain();
    endtask

    task automatic test_lock_drop();
        wdata1 = 8'h5A; wdata2 = 8'h77;
        for (int i = 0; i < 3; i++) sb.push_back('{4'b0010, 8'h5A, 1'b0});
        sb.push_back('{4'b0100, 8'h77, 1'b0});
        @(posedge clk); #1 req = 4'b0010; lock = 4'b0010;
        @(posedge clk); #1 req = 4'b0111;
        @(posedge clk);
        @(posedge clk); #1 lock = 4'b0000;
        @(posedge clk);
        @(posedge clk); #1 req = 4'b0000;
        drain();
    endtask

    task automatic test_reset_mid_own();
        wdata3 = 8'hE1; wdata0 = 8'h0F;
        sb.push_back('{4'b1000, 8'hE1, 1'b0});
        sb.push_back('{4'b0001, 8'h0F, 1'b0});
        @(posedge clk); #1 req = 4'b1000;
        @(posedge clk); #1 reset = 1'b1; req = 4'b1001;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({grant, reg_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_own got grant=%b reg_en=%b want grant=0000 reg_en=0", grant, reg_en);
        end
        reset = 1'b0;
        @(posedge clk); #1 req = 4'b0000;
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_lock_drop();
        test_reset_mid_own();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
